// File: rtl/cache_line_fill_pkg.sv
// ============================================================================
// Module      : cache_line_fill_pkg
// Description : Line geometry and refill FSM encoding, shared by the refill
//               engine and the lookup controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_line_fill_pkg;

    localparam int CLF_WORDS_PER_LINE = 8;
    localparam int CLF_OFFSET_BITS    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fill_state_e;

endpackage

`default_nettype wire

// File: rtl/fill_word_pairer.sv
// ============================================================================
// Module      : fill_word_pairer
// Description : Holds the even word of each pair and issues a dual-port write
//               (A = held word, B = current word) the cycle after the odd word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_word_pairer #(
    parameter int ADDRESS_SPACE = 12,
    parameter int DATA_SIZE     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     accept_i,
    input  logic                     odd_i,
    input  logic [DATA_SIZE-1:0]     word_i,
    input  logic [ADDRESS_SPACE-1:0] addr_i,
    output logic                     we_o,
    output logic [ADDRESS_SPACE-1:0] addr_a_o,
    output logic [DATA_SIZE-1:0]     data_a_o,
    output logic [ADDRESS_SPACE-1:0] addr_b_o,
    output logic [DATA_SIZE-1:0]     data_b_o
);

    logic [DATA_SIZE-1:0]     hold_data_q;
    logic [ADDRESS_SPACE-1:0] hold_addr_q;
    logic                     we_q;
    logic [ADDRESS_SPACE-1:0] addr_a_q;
    logic [DATA_SIZE-1:0]     data_a_q;
    logic [ADDRESS_SPACE-1:0] addr_b_q;
    logic [DATA_SIZE-1:0]     data_b_q;

    logic w_hold;
    logic w_pair;

    assign w_hold = accept_i & ~odd_i;
    assign w_pair = accept_i & odd_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_q <= '0;
            hold_addr_q <= '0;
            we_q        <= 1'b0;
            addr_a_q    <= '0;
            data_a_q    <= '0;
            addr_b_q    <= '0;
            data_b_q    <= '0;
        end else begin
            we_q <= w_pair;
            if (w_hold) begin
                hold_data_q <= word_i;
                hold_addr_q <= addr_i;
            end
            if (w_pair) begin
                addr_a_q <= hold_addr_q;
                data_a_q <= hold_data_q;
                addr_b_q <= addr_i;
                data_b_q <= word_i;
            end
        end
    end

    // Address/data buses read as zero whenever no write is in flight.
    assign we_o     = we_q;
    assign addr_a_o = we_q ? addr_a_q : '0;
    assign data_a_o = we_q ? data_a_q : '0;
    assign addr_b_o = we_q ? addr_b_q : '0;
    assign data_b_o = we_q ? data_b_q : '0;

endmodule

`default_nettype wire

// File: rtl/cache_line_fill.sv
// ============================================================================
// Module      : cache_line_fill
// Description : Cache line refill engine: requests a line, packs returning
//               words into A/B pair writes and forwards the critical word.
//               Define CACHE_LINE_FILL_CWF_EN for critical-word-first fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_line_fill
    import cache_line_fill_pkg::*;
#(
    parameter int ADDRESS_SPACE  = 12,
    parameter int DATA_SIZE      = 32,
    parameter int WORDS_PER_LINE = CLF_WORDS_PER_LINE,
    parameter int OFFSET_BITS    = CLF_OFFSET_BITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fill_req,
    input  logic [ADDRESS_SPACE-OFFSET_BITS-1:0] fill_index,
    input  logic [OFFSET_BITS-1:0]           fill_offset,
    output logic                             mem_req,
    output logic [ADDRESS_SPACE-1:0]         mem_addr,
    input  logic [DATA_SIZE-1:0]             mem_data,
    input  logic                             mem_valid,
    output logic                             mem_ready,
    output logic                             ram_we_a,
    output logic [ADDRESS_SPACE-1:0]         ram_addr_a,
    output logic [DATA_SIZE-1:0]             ram_data_a,
    output logic                             ram_we_b,
    output logic [ADDRESS_SPACE-1:0]         ram_addr_b,
    output logic [DATA_SIZE-1:0]             ram_data_b,
    output logic                             crit_valid,
    output logic [DATA_SIZE-1:0]             crit_data,
    output logic                             busy,
    output logic                             fill_done
);

    localparam int INDEX_BITS = ADDRESS_SPACE - OFFSET_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_CNT = OFFSET_BITS'(WORDS_PER_LINE - 1);

    fill_state_e state_q, state_d;

    logic [INDEX_BITS-1:0]    index_q;
    logic [OFFSET_BITS-1:0]   crit_off_q;
    logic [OFFSET_BITS-1:0]   start_off_q;
    logic [OFFSET_BITS-1:0]   start_off_d;
    logic [OFFSET_BITS-1:0]   cnt_q, cnt_d;
    logic                     crit_valid_q;
    logic [DATA_SIZE-1:0]     crit_data_q;

    logic                     w_start;
    logic                     w_accept;
    logic                     w_crit_hit;
    logic [OFFSET_BITS-1:0]   w_word_off;
    logic [ADDRESS_SPACE-1:0] w_word_addr;
    logic                     w_pair_we;

`ifdef CACHE_LINE_FILL_CWF_EN
    assign start_off_d = fill_offset;
`else
    assign start_off_d = '0;
`endif

    assign w_start    = (state_q == ST_IDLE) & fill_req;
    assign w_accept   = (state_q == ST_FILL) & mem_valid;
    // Offset arithmetic is OFFSET_BITS wide, so it wraps inside the line.
    assign w_word_off  = start_off_q + cnt_q;
    assign w_word_addr = {index_q, w_word_off};
    assign w_crit_hit  = w_accept & (w_word_off == crit_off_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        fill_done = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (fill_req) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                state_d = ST_FILL;
            end
            ST_FILL: begin
                mem_ready = 1'b1;
                if (w_accept && (cnt_q == LAST_CNT)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fill_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_start) begin
            cnt_d = '0;
        end else if (w_accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q      <= '0;
            crit_off_q   <= '0;
            start_off_q  <= '0;
            cnt_q        <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            crit_valid_q <= w_crit_hit;
            if (w_crit_hit) begin
                crit_data_q <= mem_data;
            end
            if (w_start) begin
                index_q     <= fill_index;
                crit_off_q  <= fill_offset;
                start_off_q <= start_off_d;
            end
        end
    end

    assign mem_addr   = mem_req ? {index_q, start_off_q} : '0;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;

    fill_word_pairer #(
        .ADDRESS_SPACE (ADDRESS_SPACE),
        .DATA_SIZE     (DATA_SIZE)
    ) u_pairer (
        .clk      (clk),
        .rst      (rst),
        .accept_i (w_accept),
        .odd_i    (cnt_q[0]),
        .word_i   (mem_data),
        .addr_i   (w_word_addr),
        .we_o     (w_pair_we),
        .addr_a_o (ram_addr_a),
        .data_a_o (ram_data_a),
        .addr_b_o (ram_addr_b),
        .data_b_o (ram_data_b)
    );

    // Ports A and B always write together.
    assign ram_we_a = w_pair_we;
    assign ram_we_b = w_pair_we;

endmodule

`default_nettype wire

// File: tb/tb_cache_line_fill.sv
// ============================================================================
// Module      : tb_cache_line_fill
// Description : Directed self-checking bench for cache_line_fill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_line_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fill_req = 1'b0;
    logic [8:0]  fill_index = '0;
    logic [2:0]  fill_offset = '0;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        ram_we_a;
    logic [11:0] ram_addr_a;
    logic [31:0] ram_data_a;
    logic        ram_we_b;
    logic [11:0] ram_addr_b;
    logic [31:0] ram_data_b;
    logic        crit_valid;
    logic [31:0] crit_data;
    logic        busy;
    logic        fill_done;

    int checks = 0;
    int errors = 0;

    cache_line_fill #(
        .ADDRESS_SPACE  (12),
        .DATA_SIZE      (32),
        .WORDS_PER_LINE (8),
        .OFFSET_BITS    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fill_req    (fill_req),
        .fill_index  (fill_index),
        .fill_offset (fill_offset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .ram_we_a    (ram_we_a),
        .ram_addr_a  (ram_addr_a),
        .ram_data_a  (ram_data_a),
        .ram_we_b    (ram_we_b),
        .ram_addr_b  (ram_addr_b),
        .ram_data_b  (ram_data_b),
        .crit_valid  (crit_valid),
        .crit_data   (crit_data),
        .busy        (busy),
        .fill_done   (fill_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero();
        chk("z_mem_req",    mem_req,    0);
        chk("z_mem_addr",   mem_addr,   0);
        chk("z_mem_ready",  mem_ready,  0);
        chk("z_we_a",       ram_we_a,   0);
        chk("z_we_b",       ram_we_b,   0);
        chk("z_addr_a",     ram_addr_a, 0);
        chk("z_data_a",     ram_data_a, 0);
        chk("z_addr_b",     ram_addr_b, 0);
        chk("z_data_b",     ram_data_b, 0);
        chk("z_crit_valid", crit_valid, 0);
        chk("z_crit_data",  crit_data,  0);
        chk("z_busy",       busy,       0);
        chk("z_fill_done",  fill_done,  0);
    endtask

    // One refill: gap inserts an idle mem_valid cycle after each word, poke
    // pulses fill_req during FILL and DONE, abort_after>0 resets after that
    // many accepted words.
    task automatic do_fill(input int idx, input int off, input int base,
                           input bit gap, input bit poke, input int abort_after);
        int start;
        bit odd;
        bit is_crit;
`ifdef CACHE_LINE_FILL_CWF_EN
        start = off;
`else
        start = 0;
`endif
        @(negedge clk);
        fill_req    = 1'b1;
        fill_index  = idx[8:0];
        fill_offset = off[2:0];
        @(negedge clk);
        fill_req = 1'b0;
        chk("req_pulse", mem_req, 1);
        chk("req_addr",  mem_addr, idx * 8 + start);
        chk("req_busy",  busy, 1);
        chk("req_ready", mem_ready, 0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk("fill_ready", mem_ready, 1);
            if (poke && k == 3) begin
                fill_req    = 1'b1;
                fill_index  = 9'h1ff;
                fill_offset = 3'd7;
            end
            mem_valid = 1'b1;
            mem_data  = base + k;
            @(negedge clk);
            mem_valid = 1'b0;
            fill_req  = 1'b0;
            mem_data  = 32'hdead_beef;
            odd = (k % 2) == 1;
            chk("we_a", ram_we_a, odd);
            chk("we_b", ram_we_b, odd);
            if (odd) begin
                chk("addr_a", ram_addr_a, idx * 8 + (start + k - 1) % 8);
                chk("data_a", ram_data_a, base + k - 1);
                chk("addr_b", ram_addr_b, idx * 8 + (start + k) % 8);
                chk("data_b", ram_data_b, base + k);
            end
            is_crit = ((start + k) % 8) == off;
            chk("crit_valid", crit_valid, is_crit);
            if (is_crit) chk("crit_data", crit_data, base + k);
            chk("fill_done", fill_done, k == 7);
            if (abort_after == k + 1) begin
                rst = 1'b1;
                #1;
                chk_all_zero();
                @(negedge clk);
                mem_valid = 1'b1;
                mem_data  = 32'h5555_aaaa;
                @(negedge clk);
                rst = 1'b0;
                chk("stray_ready", mem_ready, 0);
                @(negedge clk);
                chk("stray_we",   ram_we_a, 0);
                chk("stray_crit", crit_valid, 0);
                chk("stray_busy", busy, 0);
                mem_valid = 1'b0;
                return;
            end
            if (gap && k < 7) begin
                @(negedge clk);
                chk("gap_we",    ram_we_a, 0);
                chk("gap_crit",  crit_valid, 0);
                chk("gap_ready", mem_ready, 1);
            end
        end
        chk("done_busy", busy, 1);
        if (poke) begin
            fill_req    = 1'b1;
            fill_index  = 9'h1ff;
            fill_offset = 3'd7;
        end
        @(negedge clk);
        fill_req = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_req",  mem_req, 0);
        chk("idle_done", fill_done, 0);
        chk("idle_we",   ram_we_a, 0);
        if (poke) begin
            @(negedge clk);
            chk("poke_busy", busy, 0);
            chk("poke_req",  mem_req, 0);
        end
    endtask

    initial begin
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero();
        @(negedge clk);
        rst = 1'b0;

        // Sequential line at index 5: pairs (40,41)..(46,47), crit = 100.
        do_fill(5, 0, 100, 1'b0, 1'b0, 0);
        // Offset 6: mem_addr 46 with CWF, else 40 with crit on the 7th word.
        do_fill(5, 6, 200, 1'b0, 1'b0, 0);
        do_fill(2, 3, 300, 1'b1, 1'b0, 0);
        do_fill(7, 1, 400, 1'b0, 1'b1, 0);
        do_fill(3, 0, 500, 1'b0, 1'b0, 3);
        do_fill(1, 5, 600, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
